// File: rtl/trs80_clk_pkg.sv
// trs80_clk_pkg: shared turbo encodings, sequencer states and CPU divisor helper
package trs80_clk_pkg;
  localparam logic [1:0] TURBO_X1 = 2'b00;
  localparam logic [1:0] TURBO_X2 = 2'b01;
  localparam logic [1:0] TURBO_X4 = 2'b10;
  localparam logic [1:0] TURBO_X8 = 2'b11;
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} state_t;
  function automatic int unsigned div_for_turbo(input logic [1:0] turbo, input int unsigned cpu_div);
    return cpu_div >> turbo;
  endfunction
endpackage

// File: rtl/trs80_ce_div.sv
// trs80_ce_div: wrap counter with run/hold producing end-of-period and mid-period pulses
module trs80_ce_div #(
  parameter int W = 2
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         run,
  input  logic         hold,
  input  logic [W-1:0] last,
  input  logic [W-1:0] mid,
  output logic         p,
  output logic         n
);
  logic [W-1:0] cnt;
  logic         go;
  assign go = run && !hold && !reset;
  assign p  = go && cnt == last;
  assign n  = go && cnt == mid;
  always_ff @(posedge clk_sys)
    if (reset || !run) cnt <= '0;
    else if (!hold) cnt <= (cnt == last) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/trs80_clk_en.sv
// trs80_clk_en: lock-sequenced system reset plus pixel and CPU clock enables
module trs80_clk_en
  import trs80_clk_pkg::*;
#(
  parameter int unsigned PIX_DIV   = 4,
  parameter int unsigned CPU_DIV   = 24,
  parameter int unsigned LOCK_HOLD = 1024
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic [1:0] turbo,
  input  logic       pause,
  output logic       sys_reset,
  output logic       ce_pix,
  output logic       ce_cpu_p,
  output logic       ce_cpu_n
);
  localparam int LW = $clog2(LOCK_HOLD);
  localparam int CW = $clog2(CPU_DIV);
  localparam int DW = $clog2(CPU_DIV + 1);
  localparam int PW = $clog2(PIX_DIV);
  logic          s1, lk, run, pix_n_unused;
  state_t        state, state_n;
  logic [LW-1:0] lock_cnt, lock_cnt_n;
  logic [DW-1:0] cur_div;
  logic [CW-1:0] cpu_last, cpu_mid;
  always_ff @(posedge clk_sys)
    if (reset) {s1, lk} <= 2'b00;
    else {s1, lk} <= {pll_locked, s1};
  always_ff @(posedge clk_sys)
    if (reset) begin
      state    <= WAIT_LOCK;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      lock_cnt <= lock_cnt_n;
    end
  always_comb begin
    state_n    = !lk ? WAIT_LOCK :
                 state == WAIT_LOCK ? STABLE :
                 (state == STABLE && lock_cnt == LW'(LOCK_HOLD - 1)) ? RUN : state;
    lock_cnt_n = (state == STABLE && lk) ? lock_cnt + 1'b1 : '0;
  end
  assign run       = state == RUN;
  assign sys_reset = !run;
  always_ff @(posedge clk_sys)
    if (reset || !run) cur_div <= DW'(CPU_DIV);
    else if (ce_cpu_p) cur_div <= DW'(div_for_turbo(turbo, CPU_DIV));
  assign cpu_last = CW'(cur_div - 1'b1);
  assign cpu_mid  = CW'((cur_div >> 1) - 1'b1);
  trs80_ce_div #(.W(PW)) u_pix (
    .clk_sys(clk_sys),
    .reset  (reset),
    .run    (run),
    .hold   (1'b0),
    .last   (PW'(PIX_DIV - 1)),
    .mid    (PW'(PIX_DIV / 2 - 1)),
    .p      (ce_pix),
    .n      (pix_n_unused)
  );
  trs80_ce_div #(.W(CW)) u_cpu (
    .clk_sys(clk_sys),
    .reset  (reset),
    .run    (run),
    .hold   (pause),
    .last   (cpu_last),
    .mid    (cpu_mid),
    .p      (ce_cpu_p),
    .n      (ce_cpu_n)
  );
endmodule

// File: doc/trs80_clk_en.md
Name: trs80_clk_en

Overview:
- Sits directly downstream of the 42.578 MHz system PLL. Consumes its output clock and its `locked` flag.
- Generates the core's sequenced system reset, the pixel clock enable (42.578/4 = 10.6445 MHz) and the Z80 CPU clock enables (42.578/24 = 1.774 MHz nominal, with turbo multiples).
- All core logic runs on clk_sys and is gated by these enables. No derived clocks exist.

Parameters:
- PIX_DIV, 4: clk_sys cycles per ce_pix pulse.
- CPU_DIV, 24: clk_sys cycles per CPU cycle at turbo=00. Must be divisible by 8.
- LOCK_HOLD, 1024: consecutive synchronised-locked cycles required before sys_reset releases.

Ports:
- clk_sys  in  1: 42.578 MHz PLL output clock.
- reset  in  1: synchronous, active-high reset.
- pll_locked  in  1: PLL lock flag. Asynchronous to clk_sys; double-flop synchronised internally.
- turbo  in  2: CPU divider select. 00 = CPU_DIV, 01 = CPU_DIV/2, 10 = CPU_DIV/4, 11 = CPU_DIV/8.
- pause  in  1: freezes CPU enables. Pixel enable continues.
- sys_reset  out  1: core reset, active-high.
- ce_pix  out  1: one-cycle pixel enable.
- ce_cpu_p  out  1: one-cycle CPU rising-phase enable.
- ce_cpu_n  out  1: one-cycle CPU falling-phase enable.

Behaviour:
- Clock and reset: single clock, clk_sys. reset is synchronous and active-high.
- Effect of reset = 1:
  - State goes to WAIT_LOCK.
  - Sync flops, lock counter, pix_cnt and cpu_cnt go to 0.
  - cur_div loads CPU_DIV.
  - Outputs: sys_reset = 1; ce_pix = ce_cpu_p = ce_cpu_n = 0.
- Lock sync: lk = pll_locked delayed by 2 clk_sys cycles through two flops.
- State machine:
  - WAIT_LOCK: sys_reset = 1; counters held at 0. If lk = 1, go to STABLE with lock_cnt = 0.
  - STABLE: sys_reset = 1; lock_cnt increments each cycle.
    - If lk = 0, return to WAIT_LOCK.
    - When lock_cnt = LOCK_HOLD-1 with lk = 1, go to RUN.
  - RUN: sys_reset = 0; divider counters run. If lk = 0, go to WAIT_LOCK on the next edge.
    - The lock-loss transition drives sys_reset = 1 and all enables to 0 from that cycle.
    - pix_cnt and cpu_cnt are zeroed.
- Registered outputs: sys_reset falls on the first clk_sys edge after entering RUN, i.e. the first cycle of RUN.
- Pixel divider (RUN only):
  - pix_cnt counts 0 to PIX_DIV-1 and wraps.
  - ce_pix = 1 in the cycle where pix_cnt = PIX_DIV-1.
  - First ce_pix occurs in the 4th RUN cycle.
- CPU divider (RUN only):
  - cpu_cnt counts 0 to cur_div-1 and wraps.
  - ce_cpu_p = 1 when cpu_cnt = cur_div-1.
  - ce_cpu_n = 1 when cpu_cnt = cur_div/2-1. Positions: 24 → 11, 12 → 5, 6 → 2, 3 → 0.
  - p and n pulses are never asserted in the same cycle.
- Turbo change:
  - turbo is sampled only on the cycle ce_cpu_p fires; cur_div updates for the next CPU cycle.
  - A mid-cycle turbo change never shortens or extends the current CPU cycle.
  - The first CPU cycle after reset always uses CPU_DIV.
- Pause:
  - pause = 1 holds cpu_cnt and forces ce_cpu_p = ce_cpu_n = 0 in the same cycle (combinational gate on the registered compare).
  - Release resumes from the held count. No lost or duplicated phase pulse.
  - ce_pix is unaffected by pause.
- Simultaneous events:
  - reset overrides everything.
  - Lock loss overrides pause and turbo.
  - pause during the wrap cycle suppresses the wrap: no pulse, no turbo sample.
- Widths:
  - lock_cnt: clog2(LOCK_HOLD) bits.
  - cpu_cnt: clog2(CPU_DIV) bits.
  - All compares are unsigned.

Decomposition:
- Shared package trs80_clk_pkg holds:
  - turbo encoding constants: TURBO_X1 = 2'b00, TURBO_X2, TURBO_X4, TURBO_X8;
  - state enum {WAIT_LOCK, STABLE, RUN};
  - function div_for_turbo(turbo, CPU_DIV).
- One natural sub-module: trs80_ce_div. It is a parameterised wrap counter with a run/hold input, a variable modulus and p/n pulse outputs. It is instantiated twice: pixel (fixed modulus, n unused) and CPU.

Test Plan:
- Lock sequencing: reset 5 cycles, pll_locked = 1 → sys_reset stays 1 for 2 + 1 + 1024 cycles after reset release, then 0. No enable pulses before that.
- Pixel cadence: in RUN, ce_pix pulses every 4 cycles, first pulse in the 4th RUN cycle. Exactly 256 pulses in 1024 cycles.
- CPU cadence and turbo: turbo = 00 gives ce_cpu_n at count 11 and ce_cpu_p at count 23 (period 24). Set turbo = 11 at cpu_cnt = 5 → current cycle still ends at 24; subsequent periods are 3 with n at 0 and p at 2.
- Pause: assert pause at cpu_cnt = 10 for 50 cycles → no ce_cpu_* during pause and ce_pix continues (12 or 13 pulses). After release, ce_cpu_n arrives 2 cycles later.
- Lock glitch: drop pll_locked for 1 cycle in STABLE at lock_cnt = 500 → return to WAIT_LOCK; release needs a full fresh 1024. Drop in RUN → sys_reset = 1 and enables at 0 three cycles after the drop.
- Reset mid-run: reset = 1 while ce_cpu_p would fire → no pulse, sys_reset = 1 next edge, cur_div = 24 after re-lock.
